ddr_cmd_responder: RTL

//   Memory-side DDR3 command decoder and responder. It samples the command and address bus on ck_t,

---
 rtl/ddr_cmd_responder_if.sv | 41 ++++
 rtl/ddr_cmd_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_responder_if.sv
// Command/address bus from the controller plus the decoded response from the memory-side
// responder. The controller is the master and the responder is the slave.
interface ddr_cmd_responder_if #(
    parameter int ROW_WIDTH = 14,
    parameter int BA_WIDTH  = 3,
    parameter int COL_WIDTH = 10
);
    localparam int NBANK = 2 ** BA_WIDTH;

    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [BA_WIDTH-1:0]  ba;
    logic [ROW_WIDTH-1:0] a;

    logic                 cmd_valid;
    logic [2:0]           cmd_code;
    logic [BA_WIDTH-1:0]  cmd_ba;
    logic [ROW_WIDTH-1:0] cmd_row;
    logic [COL_WIDTH-1:0] cmd_col;
    logic [NBANK-1:0]     bank_open;
    logic                 rd_data_en;
    logic                 wr_data_en;
    logic [7:0]           burst_idx;
    logic                 err_valid;
    logic [2:0]           err_code;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, a,
        input  cmd_valid, cmd_code, cmd_ba, cmd_row, cmd_col, bank_open,
               rd_data_en, wr_data_en, burst_idx, err_valid, err_code
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, a,
        output cmd_valid, cmd_code, cmd_ba, cmd_row, cmd_col, bank_open,
               rd_data_en, wr_data_en, burst_idx, err_valid, err_code
    );
endinterface

// File: rtl/ddr_cmd_responder.sv
// DDR3 memory-side command decoder: tracks per-bank open state and rows, enforces basic
// protocol rules and schedules the CL/CWL-delayed read/write data windows.
module ddr_cmd_responder #(
    parameter int ROW_WIDTH = 14,
    parameter int BA_WIDTH  = 3,
    parameter int COL_WIDTH = 10,
    parameter int CL        = 6,
    parameter int CWL       = 5,
    parameter int BL        = 8,
    parameter int TRCD      = 6
) (
    input  logic               ck_t,
    input  logic               reset,
    ddr_cmd_responder_if.slave bus
);
    localparam int NBANK = 2 ** BA_WIDTH;
    localparam int BEATS = BL / 2;
    localparam int DEPTH = ((CL > CWL) ? CL : CWL) + BEATS;
    localparam int CNT_W = $clog2(TRCD + 1);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;
    localparam logic [2:0] CMD_MRS  = 3'd7;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
    localparam logic [2:0] ERR_CLOSED   = 3'd2;
    localparam logic [2:0] ERR_TRCD     = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN = 3'd4;
    localparam logic [2:0] ERR_OVERLAP  = 3'd5;

    // Schedule bit j (after this cycle's shift) stands for the cycle j+1 edges ahead.
    localparam logic [DEPTH-1:0] BEAT_ONES = {{(DEPTH-BEATS){1'b0}}, {BEATS{1'b1}}};
    localparam logic [DEPTH-1:0] ONE_HOT   = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0] RD_MASK   = BEAT_ONES << (CL - 1);
    localparam logic [DEPTH-1:0] WR_MASK   = BEAT_ONES << (CWL - 1);
    localparam logic [DEPTH-1:0] RD_START  = ONE_HOT << (CL - 1);
    localparam logic [DEPTH-1:0] WR_START  = ONE_HOT << (CWL - 1);

    logic [NBANK-1:0]     r_bank_open;
    logic [ROW_WIDTH-1:0] r_row  [NBANK];
    logic [CNT_W-1:0]     r_trcd [NBANK];
    logic [DEPTH-1:0]     r_rd_sched;
    logic [DEPTH-1:0]     r_wr_sched;
    logic [DEPTH-1:0]     r_start_sched;
    logic [7:0]           r_burst_idx;
    logic                 r_cmd_valid;
    logic [2:0]           r_cmd_code;
    logic [BA_WIDTH-1:0]  r_cmd_ba;
    logic [ROW_WIDTH-1:0] r_cmd_row;
    logic [COL_WIDTH-1:0] r_cmd_col;
    logic                 r_err_valid;
    logic [2:0]           r_err_code;

    logic [2:0]       w_cmd;
    logic [2:0]       w_err;
    logic             w_accept;
    logic             w_is_col;
    logic             w_overlap;
    logic [DEPTH-1:0] w_win_mask;
    logic [DEPTH-1:0] w_start_mask;
    logic [DEPTH-1:0] w_rd_shift;
    logic [DEPTH-1:0] w_wr_shift;
    logic [DEPTH-1:0] w_rd_next;
    logic [DEPTH-1:0] w_wr_next;
    logic [DEPTH-1:0] w_start_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cmd = CMD_NOP;
        if (bus.cke && !bus.cs_n) begin
            case ({bus.ras_n, bus.cas_n, bus.we_n})
                3'b011:  w_cmd = CMD_ACT;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b010:  w_cmd = bus.a[10] ? CMD_PREA : CMD_PRE;
                3'b001:  w_cmd = CMD_REF;
                3'b000:  w_cmd = CMD_MRS;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    assign w_is_col     = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
    assign w_win_mask   = (w_cmd == CMD_WR) ? WR_MASK : RD_MASK;
    assign w_start_mask = (w_cmd == CMD_WR) ? WR_START : RD_START;
    assign w_rd_shift   = r_rd_sched >> 1;
    assign w_wr_shift   = r_wr_sched >> 1;
    assign w_overlap    = |(w_win_mask & (w_rd_shift | w_wr_shift));

    always_comb begin
        w_err = ERR_NONE;
        case (w_cmd)
            CMD_ACT: begin
                if (r_bank_open[bus.ba]) w_err = ERR_ACT_OPEN;
            end
            CMD_RD, CMD_WR: begin
                if (!r_bank_open[bus.ba])        w_err = ERR_CLOSED;
                else if (r_trcd[bus.ba] != '0)   w_err = ERR_TRCD;
                else if (w_overlap)              w_err = ERR_OVERLAP;
            end
            CMD_REF, CMD_MRS: begin
                if (|r_bank_open) w_err = ERR_REF_OPEN;
            end
            default: w_err = ERR_NONE;
        endcase
    end

    assign w_accept     = (w_cmd != CMD_NOP) && (w_err == ERR_NONE);
    assign w_rd_next    = w_rd_shift | ((w_accept && w_cmd == CMD_RD) ? RD_MASK : '0);
    assign w_wr_next    = w_wr_shift | ((w_accept && w_cmd == CMD_WR) ? WR_MASK : '0);
    assign w_start_next = (r_start_sched >> 1) | ((w_accept && w_is_col) ? w_start_mask : '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck_t) begin
        if (reset) begin
            r_bank_open   <= '0;
            // NOTE: the row/tRCD arrays are small register files with a defined reset value, so they are cleared here.
            for (int b = 0; b < NBANK; b++) begin
                r_row[b]  <= '0;
                r_trcd[b] <= '0;
            end
            r_rd_sched    <= '0;
            r_wr_sched    <= '0;
            r_start_sched <= '0;
            r_burst_idx   <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= CMD_NOP;
            r_cmd_ba      <= '0;
            r_cmd_row     <= '0;
            r_cmd_col     <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (r_trcd[b] != '0) r_trcd[b] <= r_trcd[b] - CNT_W'(1);
            end

            r_rd_sched    <= w_rd_next;
            r_wr_sched    <= w_wr_next;
            r_start_sched <= w_start_next;
            // A start marker restarts the index so seamless bursts count 0..BEATS-1 again.
            if (w_rd_next[0] || w_wr_next[0])
                r_burst_idx <= w_start_next[0] ? 8'd0 : r_burst_idx + 8'd1;
            else
                r_burst_idx <= 8'd0;

            r_cmd_valid <= w_accept;
            r_cmd_code  <= w_accept ? w_cmd : CMD_NOP;
            r_cmd_ba    <= w_accept ? bus.ba : '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_err_valid <= (w_cmd != CMD_NOP) && (w_err != ERR_NONE);
            r_err_code  <= (w_cmd != CMD_NOP) ? w_err : ERR_NONE;

            if (w_accept) begin
                case (w_cmd)
                    CMD_ACT: begin
                        r_bank_open[bus.ba] <= 1'b1;
                        r_row[bus.ba]       <= bus.a;
                        r_trcd[bus.ba]      <= CNT_W'(TRCD - 1);
                        r_cmd_row           <= bus.a;
                    end
                    CMD_RD, CMD_WR: begin
                        r_cmd_row <= r_row[bus.ba];
                        r_cmd_col <= bus.a[COL_WIDTH-1:0];
                        if (bus.a[10]) r_bank_open[bus.ba] <= 1'b0;
                    end
                    CMD_PRE:  r_bank_open[bus.ba] <= 1'b0;
                    CMD_PREA: r_bank_open         <= '0;
                    default:  ;
                endcase
            end
        end
    end

    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_code   = r_cmd_code;
    assign bus.cmd_ba     = r_cmd_ba;
    assign bus.cmd_row    = r_cmd_row;
    assign bus.cmd_col    = r_cmd_col;
    assign bus.bank_open  = r_bank_open;
    assign bus.rd_data_en = r_rd_sched[0];
    assign bus.wr_data_en = r_wr_sched[0];
    assign bus.burst_idx  = r_burst_idx;
    assign bus.err_valid  = r_err_valid;
    assign bus.err_code   = r_err_code;
endmodule
